// File: rtl/time_set_controller.sv
// rtl/time_set_controller.sv - debounced SET/INC keys driving an hour/minute edit FSM with BCD preset outputs
module time_set_controller #(
   parameter int DEBOUNCE_CYCLES = 2,
   parameter int TIMEOUT_CYCLES  = 100,
   parameter int BLINK_CYCLES    = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       set_key,
   input  logic       inc_key,
   input  logic [1:0] cur_h_t,
   input  logic [3:0] cur_h_u,
   input  logic [2:0] cur_m_t,
   input  logic [3:0] cur_m_u,
   output logic [1:0] set_h_t,
   output logic [3:0] set_h_u,
   output logic [2:0] set_m_t,
   output logic [3:0] set_m_u,
   output logic       load,
   output logic       edit_h,
   output logic       edit_m,
   output logic       blink
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] EDIT_H = 2'd1;
   localparam logic [1:0] EDIT_M = 2'd2;
   localparam logic [1:0] COMMIT = 2'd3;

   localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0] TO_MAX = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] BL_MAX = 8'(BLINK_CYCLES - 1);

   // bit 0 = SET, bit 1 = INC
   logic [1:0] key_s1, key_s2, key_deb, key_deb_q, key_ev;
   logic [3:0] db_cnt [2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_s1    <= '0;
         key_s2    <= '0;
         key_deb   <= '0;
         key_deb_q <= '0;
         key_ev    <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         key_s1    <= {inc_key, set_key};
         key_s2    <= key_s1;
         key_deb_q <= key_deb;
         key_ev    <= key_deb & ~key_deb_q;
         for (int i = 0; i < 2; i++) begin
            if (key_s2[i] != key_deb[i]) begin
               if (db_cnt[i] == DB_MAX) begin
                  key_deb[i] <= key_s2[i];
                  db_cnt[i]  <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 4'd1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   logic       set_ev, inc_ev, any_ev;
   logic [1:0] state, state_nxt;
   logic [7:0] to_cnt, bl_cnt;
   logic       timeout_hit, in_edit_nxt, edit_entry;
   logic       h_ok, m_ok;
   logic [1:0] inc_h_t;
   logic [3:0] inc_h_u;
   logic [2:0] inc_m_t;
   logic [3:0] inc_m_u;

   assign set_ev = key_ev[0];
   assign inc_ev = key_ev[1];
   assign any_ev = set_ev | inc_ev;

   assign timeout_hit = (to_cnt == TO_MAX) && !any_ev;
   assign in_edit_nxt = (state_nxt == EDIT_H) || (state_nxt == EDIT_M);
   assign edit_entry  = in_edit_nxt && (state_nxt != state);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (set_ev) state_nxt = EDIT_H;
         EDIT_H: if (set_ev) state_nxt = EDIT_M;
                 else if (timeout_hit) state_nxt = IDLE;
         EDIT_M: if (set_ev) state_nxt = COMMIT;
                 else if (timeout_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Capture validity and BCD successors of the values being edited
   always_comb begin
      h_ok = ((cur_h_t < 2'd2) && (cur_h_u <= 4'd9)) ||
             ((cur_h_t == 2'd2) && (cur_h_u <= 4'd3));
      m_ok = (cur_m_t <= 3'd5) && (cur_m_u <= 4'd9);

      inc_h_t = set_h_t;
      inc_h_u = set_h_u + 4'd1;
      if ((set_h_t == 2'd2) && (set_h_u == 4'd3)) begin
         inc_h_t = 2'd0;
         inc_h_u = 4'd0;
      end else if (set_h_u == 4'd9) begin
         inc_h_t = set_h_t + 2'd1;
         inc_h_u = 4'd0;
      end

      inc_m_t = set_m_t;
      inc_m_u = set_m_u + 4'd1;
      if ((set_m_t == 3'd5) && (set_m_u == 4'd9)) begin
         inc_m_t = 3'd0;
         inc_m_u = 4'd0;
      end else if (set_m_u == 4'd9) begin
         inc_m_t = set_m_t + 3'd1;
         inc_m_u = 4'd0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         set_h_t <= '0;
         set_h_u <= '0;
         set_m_t <= '0;
         set_m_u <= '0;
         load    <= 1'b0;
         edit_h  <= 1'b0;
         edit_m  <= 1'b0;
         blink   <= 1'b0;
         to_cnt  <= '0;
         bl_cnt  <= '0;
      end else begin
         state  <= state_nxt;
         edit_h <= (state_nxt == EDIT_H);
         edit_m <= (state_nxt == EDIT_M);
         load   <= (state_nxt == COMMIT);

         if ((state == IDLE) && set_ev) begin
            set_h_t <= h_ok ? cur_h_t : 2'd0;
            set_h_u <= h_ok ? cur_h_u : 4'd0;
            set_m_t <= m_ok ? cur_m_t : 3'd0;
            set_m_u <= m_ok ? cur_m_u : 4'd0;
         end else if ((state == EDIT_H) && inc_ev && !set_ev) begin
            set_h_t <= inc_h_t;
            set_h_u <= inc_h_u;
         end else if ((state == EDIT_M) && inc_ev && !set_ev) begin
            set_m_t <= inc_m_t;
            set_m_u <= inc_m_u;
         end

         if (in_edit_nxt && !edit_entry && !any_ev) to_cnt <= to_cnt + 8'd1;
         else                                       to_cnt <= '0;

         // Blink phase restarts high whenever the edited digit changes or edit begins
         if (!in_edit_nxt) begin
            blink  <= 1'b0;
            bl_cnt <= '0;
         end else if (edit_entry || inc_ev) begin
            blink  <= 1'b1;
            bl_cnt <= '0;
         end else if (bl_cnt == BL_MAX) begin
            blink  <= ~blink;
            bl_cnt <= '0;
         end else begin
            bl_cnt <= bl_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_time_set_controller.sv
// tb/tb_time_set_controller.sv - randomized and directed self-checking bench for time_set_controller
module tb_time_set_controller;

   localparam int D    = 2;
   localparam int T    = 100;
   localparam int B    = 5;
   localparam int MAXC = 60000;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       set_key = 1'b0;
   logic       inc_key = 1'b0;
   logic [1:0] cur_h_t = '0;
   logic [3:0] cur_h_u = '0;
   logic [2:0] cur_m_t = '0;
   logic [3:0] cur_m_u = '0;
   logic [1:0] set_h_t;
   logic [3:0] set_h_u;
   logic [2:0] set_m_t;
   logic [3:0] set_m_u;
   logic       load, edit_h, edit_m, blink;

   time_set_controller #(
      .DEBOUNCE_CYCLES(D),
      .TIMEOUT_CYCLES (T),
      .BLINK_CYCLES   (B)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .set_key(set_key),
      .inc_key(inc_key),
      .cur_h_t(cur_h_t),
      .cur_h_u(cur_h_u),
      .cur_m_t(cur_m_t),
      .cur_m_u(cur_m_u),
      .set_h_t(set_h_t),
      .set_h_u(set_h_u),
      .set_m_t(set_m_t),
      .set_m_u(set_m_u),
      .load   (load),
      .edit_h (edit_h),
      .edit_m (edit_m),
      .blink  (blink)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit ev_s [MAXC];
   bit ev_i [MAXC];
   bit run_cmp = 0;
   int load_cnt = 0;
   int load_val = 0;

   // Model: mode 0 idle, 1 hours, 2 minutes, 3 commit; time kept as plain integers
   int m_mode = 0, m_hr = 0, m_mn = 0, m_since = 0, m_bk = 0;

   task automatic model_step(input bit s, input bit i);
      int hr_in, mn_in;
      case (m_mode)
         0: if (s) begin
               hr_in = int'(cur_h_t) * 10 + int'(cur_h_u);
               mn_in = int'(cur_m_t) * 10 + int'(cur_m_u);
               m_hr = (cur_h_u <= 9 && hr_in <= 23) ? hr_in : 0;
               m_mn = (cur_m_u <= 9 && cur_m_t <= 5) ? mn_in : 0;
               m_mode = 1; m_since = 0; m_bk = 0;
            end
         1, 2: if (s) begin
               m_mode = m_mode + 1; m_since = 0; m_bk = 0;
            end else if (i) begin
               if (m_mode == 1) m_hr = (m_hr + 1) % 24;
               else             m_mn = (m_mn + 1) % 60;
               m_since = 0; m_bk = 0;
            end else begin
               m_since++; m_bk++;
               if (m_since == T) m_mode = 0;
            end
         default: m_mode = 0;
      endcase
   endtask

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!reset) begin
         m_mode = 0; m_hr = 0; m_mn = 0; m_since = 0; m_bk = 0;
      end else if (cyc < MAXC) begin
         model_step(ev_s[cyc], ev_i[cyc]);
      end else begin
         model_step(1'b0, 1'b0);
      end
   end

   always @(negedge clk) begin
      logic [16:0] act, expv;
      logic        bl;
      if (load) begin
         load_cnt++;
         load_val = (int'(set_h_t) * 10 + int'(set_h_u)) * 100 + int'(set_m_t) * 10 + int'(set_m_u);
      end
      if (run_cmp) begin
         bl   = (m_mode == 1 || m_mode == 2) && ((m_bk / B) % 2 == 0);
         act  = {set_h_t, set_h_u, set_m_t, set_m_u, load, edit_h, edit_m, blink};
         expv = {2'(m_hr / 10), 4'(m_hr % 10), 3'(m_mn / 10), 4'(m_mn % 10),
                 m_mode == 3, m_mode == 1, m_mode == 2, bl};
         checks++;
         if (act !== expv) begin
            errors++;
            $display("FAIL cycle_cmp cyc=%0d actual=%h required=%h", cyc, act, expv);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   function automatic int shown();
      return (int'(set_h_t) * 10 + int'(set_h_u)) * 100 + int'(set_m_t) * 10 + int'(set_m_u);
   endfunction

   task automatic tick(input bit s, input bit i);
      set_key = s;
      inc_key = i;
      @(negedge clk);
      #1;
   endtask

   // A raw pulse of length >= D first sampled at edge cyc+1 is acted on at edge cyc+1+D+3
   task automatic sched(input int ls, input int li);
      int e;
      e = cyc + 1 + D + 3;
      if (e < MAXC) begin
         if (ls >= D) ev_s[e] = 1'b1;
         if (li >= D) ev_i[e] = 1'b1;
      end
   endtask

   task automatic pulse(input int ls, input int li, input int gap);
      int n;
      sched(ls, li);
      n = ((ls > li) ? ls : li) + gap;
      for (int j = 0; j < n; j++) tick(j < ls, j < li);
   endtask

   task automatic press_set();
      pulse(3, 0, 6);
   endtask

   task automatic press_inc();
      pulse(0, 3, 6);
   endtask

   task automatic set_cur(input int ht, input int hu, input int mt, input int mu);
      cur_h_t = 2'(ht);
      cur_h_u = 4'(hu);
      cur_m_t = 3'(mt);
      cur_m_u = 4'(mu);
   endtask

   task automatic clear_sched();
      for (int k = 0; k < MAXC; k++) begin
         ev_s[k] = 1'b0;
         ev_i[k] = 1'b0;
      end
   endtask

   initial begin
      int n0, r, ls, li;
      @(negedge clk);
      #1;
      run_cmp = 1;

      // T1: reset held with keys toggling
      for (int j = 0; j < 10; j++) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("t1_reset_outputs", int'({set_h_t, set_h_u, set_m_t, set_m_u, load, edit_h, edit_m, blink}), 0);
      reset = 1'b1;
      for (int j = 0; j < 50; j++) tick(1'b0, 1'b0);
      chk("t1_no_load", load_cnt, 0);

      // T2: full edit 12:34 -> 15:36
      set_cur(1, 2, 3, 4);
      press_set();
      chk("t2_edit_h", int'(edit_h), 1);
      repeat (3) press_inc();
      press_set();
      chk("t2_edit_m", int'(edit_m), 1);
      repeat (2) press_inc();
      n0 = load_cnt;
      press_set();
      chk("t2_load_count", load_cnt - n0, 1);
      chk("t2_load_value", load_val, 1536);

      // T3: wraps
      set_cur(2, 3, 5, 9);
      press_set(); press_inc();
      chk("t3_hour_wrap", shown(), 59);
      press_set(); press_inc(); press_set();
      chk("t3_load_0000", load_val, 0);
      set_cur(0, 9, 0, 9);
      press_set(); press_inc(); press_set(); press_inc(); press_set();
      chk("t3_load_1010", load_val, 1010);

      // T4: glitches, exact latency, held key
      set_cur(1, 0, 0, 0);
      press_set();
      repeat (3) pulse(0, 1, 6);
      chk("t4_glitch", shown(), 1000);
      sched(0, 30);
      for (int j = 1; j <= 30; j++) begin
         tick(1'b0, 1'b1);
         if (j == D + 3) chk("t4_before_edge", shown(), 1000);
         if (j == D + 4) chk("t4_at_edge", shown(), 1100);
      end
      repeat (6) tick(1'b0, 1'b0);
      chk("t4_held_single", shown(), 1100);
      press_set(); press_set();
      chk("t4_load", load_val, 1100);

      // T5: collision then timeout
      set_cur(1, 2, 3, 4);
      press_set();
      pulse(4, 4, 6);
      chk("t5_collision_edit_m", int'(edit_m), 1);
      chk("t5_collision_hours", shown(), 1234);
      n0 = load_cnt;
      repeat (80) tick(1'b0, 1'b0);
      chk("t5_before_timeout", int'(edit_m), 1);
      repeat (30) tick(1'b0, 1'b0);
      chk("t5_after_timeout", int'({edit_h, edit_m}), 0);
      chk("t5_no_load", load_cnt, n0);
      chk("t5_values_kept", shown(), 1234);

      // Out-of-range capture
      set_cur(2, 4, 6, 9);
      press_set();
      chk("clamp_both", shown(), 0);
      press_set(); press_set();
      set_cur(1, 9, 4, 10);
      press_set();
      chk("clamp_minutes", shown(), 1900);
      press_set(); press_set();

      // T6: reset mid-edit
      set_cur(0, 8, 1, 5);
      press_set(); press_set();
      chk("t6_in_edit_m", int'(edit_m), 1);
      n0 = load_cnt;
      reset = 1'b0;
      clear_sched();
      #1;
      chk("t6_async_edit_m", int'(edit_m), 0);
      chk("t6_async_values", shown(), 0);
      tick(1'b0, 1'b0);
      reset = 1'b1;
      tick(1'b0, 1'b0);
      chk("t6_no_load", load_cnt, n0);
      set_cur(0, 7, 4, 5);
      press_set();
      chk("t6_recapture", shown(), 745);
      chk("t6_edit_h", int'(edit_h), 1);

      // Randomized traffic against the model
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 9) == 0) set_cur(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                                                int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
         else set_cur(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 9)));
         r  = int'($urandom_range(0, 99));
         ls = 0;
         li = 0;
         if (r < 45)      li = int'($urandom_range(D, 12));
         else if (r < 70) ls = int'($urandom_range(D, 12));
         else if (r < 78) begin ls = int'($urandom_range(D, 8)); li = int'($urandom_range(D, 8)); end
         else if (r < 88) begin ls = int'($urandom_range(0, 1)); li = int'($urandom_range(0, 1)); end
         else if (r < 91) li = 30;
         if (r >= 97) begin
            reset = 1'b0;
            clear_sched();
            tick(1'b0, 1'b0);
            tick(1'b0, 1'b0);
            reset = 1'b1;
            tick(1'b0, 1'b0);
         end else if (r >= 91) begin
            repeat (int'($urandom_range(105, 130))) tick(1'b0, 1'b0);
         end else begin
            pulse(ls, li, int'($urandom_range(D + 2, 12)));
         end
      end

      repeat (5) tick(1'b0, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
